// File: rtl/leds_racer_pkg.sv
// rtl/leds_racer_pkg.sv - player/state types and GRB colour helper for the racer LED frame scheduler
package leds_racer_pkg;

    localparam int NUM_PLAYERS = 4;

    typedef enum logic [1:0] {GREEN, RED, BLUE, YELLOW} player_t;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EMIT, S_GAP} state_t;

    // GRB ordering on the wire: G in [23:16], R in [15:8], B in [7:0]
    function automatic logic [23:0] grb_color(input player_t p, input logic [7:0] i);
        case (p)
            GREEN:   return {i, 8'h00, 8'h00};
            RED:     return {8'h00, i, 8'h00};
            BLUE:    return {16'h0000, i};
            default: return {i, i, 8'h00};
        endcase
    endfunction

endpackage

// File: rtl/leds_racer_cell_arbiter.sv
// rtl/leds_racer_cell_arbiter.sv - picks the single player that owns one LED cell
module leds_racer_cell_arbiter
    import leds_racer_pkg::*;
#(
    parameter int POS_W = 6
)(
    input  logic [POS_W-1:0]                  idx,
    input  logic [NUM_PLAYERS-1:0][POS_W-1:0] pos,
    input  player_t                           rot_ptr,
    output logic                              hit,
    output player_t                           winner
);

    logic [1:0] cand;

    // Scan from the lowest priority up so the first contender at or after rot_ptr wins last
    always_comb begin
        hit    = 1'b0;
        winner = GREEN;
        cand   = 2'd0;
        for (int k = NUM_PLAYERS - 1; k >= 0; k--) begin
            cand = rot_ptr + 2'(k);
            if (pos[cand] == idx) begin
                hit    = 1'b1;
                winner = player_t'(cand);
            end
        end
    end

endmodule

// File: rtl/leds_racer_frame_scheduler.sv
// rtl/leds_racer_frame_scheduler.sv - snapshots player positions and streams one GRB word per LED
// Optional LEDS_RACER_SHARED_ROTATE_EN: round-robin shared-cell priority instead of fixed green>red>blue>yellow.
module leds_racer_frame_scheduler
    import leds_racer_pkg::*;
#(
    parameter int          LED_COUNT  = 49,
    parameter int          POS_W      = 6,
    parameter int          GAP_CYCLES = 14000,
    parameter logic [7:0]  INTENSITY  = 8'h0F
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             update_req,
    input  logic [POS_W-1:0] green_pos,
    input  logic [POS_W-1:0] red_pos,
    input  logic [POS_W-1:0] blue_pos,
    input  logic [POS_W-1:0] yellow_pos,
    input  logic             pix_ready,
    output logic             pix_valid,
    output logic [23:0]      pix_data,
    output logic [POS_W-1:0] led_index,
    output logic             frame_busy,
    output logic             update_frame
);

    localparam int               GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [POS_W-1:0] LAST_LED = POS_W'(LED_COUNT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    state_t                            state, next_state;
    logic [NUM_PLAYERS-1:0][POS_W-1:0] snap_pos;
    logic [GAP_W-1:0]                  gap_cnt;
    logic                              pending;
    logic                              xfer, last_xfer, gap_done;
    logic                              hit;
    player_t                           winner;
    player_t                           snap_rot;

    assign xfer      = pix_valid & pix_ready;
    assign last_xfer = xfer && (led_index == LAST_LED);
    assign gap_done  = (state == S_GAP) && (gap_cnt == GAP_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (update_req) next_state = S_LOAD;
            S_LOAD: next_state = S_EMIT;
            S_EMIT: if (last_xfer) next_state = S_GAP;
            S_GAP:  if (gap_done) next_state = (pending || update_req) ? S_LOAD : S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        pix_valid    = (state == S_EMIT);
        update_frame = (state == S_LOAD);
        frame_busy   = (state != S_IDLE);
        pix_data     = (pix_valid && hit) ? grb_color(winner, INTENSITY) : 24'h000000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snap_pos  <= '0;
            led_index <= '0;
            gap_cnt   <= '0;
            pending   <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    snap_pos  <= {yellow_pos, blue_pos, red_pos, green_pos};
                    led_index <= '0;
                end
                S_EMIT: begin
                    gap_cnt <= '0;
                    if (xfer && !last_xfer) led_index <= led_index + 1'b1;
                end
                S_GAP:  gap_cnt <= gap_cnt + 1'b1;
                default: ;
            endcase
            // A request landing in LOAD itself must survive the clear
            if (state == S_LOAD)
                pending <= update_req;
            else if (update_req && state != S_IDLE)
                pending <= 1'b1;
        end
    end

`ifdef LEDS_RACER_SHARED_ROTATE_EN
    player_t rot_ptr;

    // snap_rot holds the pointer value this frame was loaded with; rot_ptr already points at the next one
    always_ff @(posedge clk) begin
        if (rst) begin
            rot_ptr  <= GREEN;
            snap_rot <= GREEN;
        end else if (state == S_LOAD) begin
            snap_rot <= rot_ptr;
            rot_ptr  <= player_t'(rot_ptr + 2'd1);
        end
    end
`else
    assign snap_rot = GREEN;
`endif

    leds_racer_cell_arbiter #(
        .POS_W (POS_W)
    ) u_arbiter (
        .idx     (led_index),
        .pos     (snap_pos),
        .rot_ptr (snap_rot),
        .hit     (hit),
        .winner  (winner)
    );

endmodule

// File: tb/tb_leds_racer_frame_scheduler.sv
// tb/tb_leds_racer_frame_scheduler.sv - randomized self-checking bench for the racer frame scheduler
// Follows LEDS_RACER_SHARED_ROTATE_EN to pick the expected shared-cell priority.
`timescale 1ns/1ps
module tb_leds_racer_frame_scheduler;

    localparam int         LC    = 5;
    localparam int         PW    = 6;
    localparam int         GAP   = 3;
    localparam logic [7:0] INT_I = 8'h0F;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          update_req = 1'b0;
    logic          pix_ready = 1'b1;
    logic [PW-1:0] green_pos = '0, red_pos = '0, blue_pos = '0, yellow_pos = '0;
    logic          pix_valid, frame_busy, update_frame;
    logic [23:0]   pix_data;
    logic [PW-1:0] led_index;

    always #5 clk = ~clk;

    leds_racer_frame_scheduler #(
        .LED_COUNT  (LC),
        .POS_W      (PW),
        .GAP_CYCLES (GAP),
        .INTENSITY  (INT_I)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .update_req   (update_req),
        .green_pos    (green_pos),
        .red_pos      (red_pos),
        .blue_pos     (blue_pos),
        .yellow_pos   (yellow_pos),
        .pix_ready    (pix_ready),
        .pix_valid    (pix_valid),
        .pix_data     (pix_data),
        .led_index    (led_index),
        .frame_busy   (frame_busy),
        .update_frame (update_frame)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: positions for the frame and frames completed since reset
    int posv[4];
    int frames_done = 0;

    function automatic logic [23:0] player_colour(input int p);
        case (p)
            0:       return {INT_I, 16'h0000};
            1:       return {8'h00, INT_I, 8'h00};
            2:       return {16'h0000, INT_I};
            default: return {INT_I, INT_I, 8'h00};
        endcase
    endfunction

    function automatic logic [23:0] expect_pixel(input int led, input int frame_no);
        int first;
`ifdef LEDS_RACER_SHARED_ROTATE_EN
        first = frame_no % 4;
`else
        first = 0;
`endif
        for (int k = 0; k < 4; k++)
            if (posv[(first + k) % 4] == led) return player_colour((first + k) % 4);
        return 24'h000000;
    endfunction

    int ready_mode = 0;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       pix_ready = 1'b1;
            1:       pix_ready = ~pix_ready;
            default: pix_ready = 1'($urandom_range(0, 1));
        endcase
    end

    logic [29:0]   xfer_q[$];
    int            uf_count = 0;
    logic          prev_stall = 1'b0;
    logic [PW-1:0] prev_idx = '0;
    logic [23:0]   prev_data = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", pix_valid, 1);
                check("stall_idx", led_index, prev_idx);
                check("stall_data", pix_data, prev_data);
            end
            if (pix_valid && pix_ready) xfer_q.push_back({led_index, pix_data});
            if (update_frame) uf_count++;
            prev_stall = pix_valid && !pix_ready;
            prev_idx   = led_index;
            prev_data  = pix_data;
        end
    end

    task automatic do_frames(input int nfr, input bit check_lat, input bit extra, input bit scramble);
        int          busy_cyc, budget, uf0, n;
        bit          first;
        logic [29:0] e;
        green_pos  = PW'(posv[0]);
        red_pos    = PW'(posv[1]);
        blue_pos   = PW'(posv[2]);
        yellow_pos = PW'(posv[3]);
        xfer_q.delete();
        uf0 = uf_count;
        @(posedge clk); #1 update_req = 1'b1;
        @(negedge clk);
        if (check_lat) check("uf_before_load", update_frame, 0);
        @(posedge clk); #1 update_req = 1'b0;
        @(negedge clk);
        if (check_lat) begin
            check("uf_pulse", update_frame, 1);
            check("valid_in_load", pix_valid, 0);
        end
        busy_cyc = 0;
        budget   = 4000;
        first    = 1'b1;
        while (frame_busy && budget > 0) begin
            busy_cyc++;
            update_req = extra && (uf_count - uf0 == 1) && pix_valid && !led_index[0];
            if (scramble && pix_valid) begin
                green_pos  = PW'($urandom);
                red_pos    = PW'($urandom);
                blue_pos   = PW'($urandom);
                yellow_pos = PW'($urandom);
            end
            @(negedge clk);
            if (first && check_lat) begin
                check("first_valid", pix_valid, 1);
                check("first_idx", led_index, 0);
            end
            first = 1'b0;
            budget--;
        end
        update_req = 1'b0;
        check("frame_done", budget > 0, 1);
        if (ready_mode == 0) check("busy_cycles", busy_cyc, nfr * (1 + LC + GAP));
        repeat (3) @(negedge clk);
        check("frame_pulses", uf_count - uf0, nfr);
        check("idle_after", frame_busy, 0);
        check("xfer_count", xfer_q.size(), nfr * LC);
        for (int f = 0; f < nfr; f++) begin
            for (int i = 0; i < LC; i++) begin
                n = f * LC + i;
                e = (n < xfer_q.size()) ? xfer_q[n] : '1;
                check("pix_idx", e[29:24], i);
                check("pix_data", e[23:0], expect_pixel(i, frames_done + f));
            end
        end
        frames_done += nfr;
    endtask

    initial begin
        int budget;
        posv = '{0, 0, 0, 0};
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_valid", pix_valid, 0);
        check("rst_data", pix_data, 0);
        check("rst_idx", led_index, 0);
        check("rst_busy", frame_busy, 0);
        check("rst_uf", update_frame, 0);

        // every player on LED 2, four frames right after reset
        posv = '{2, 2, 2, 2};
        for (int f = 0; f < 4; f++) do_frames(1, f == 0, 1'b0, 1'b0);

        posv = '{0, 1, 2, 3};
        do_frames(1, 1'b1, 1'b0, 1'b0);
        ready_mode = 1;
        do_frames(1, 1'b0, 1'b0, 1'b0);
        ready_mode = 0;

        // three requests while frame 1 is emitting coalesce into one follow-up
        posv = '{4, 3, 1, 0};
        do_frames(2, 1'b0, 1'b1, 1'b0);

        posv = '{1, 3, 4, 60};
        do_frames(1, 1'b0, 1'b0, 1'b0);

        // reset while presenting LED 2
        @(posedge clk); #1 update_req = 1'b1;
        @(posedge clk); #1 update_req = 1'b0;
        budget = 50;
        @(negedge clk);
        while (!(pix_valid && led_index == 2) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("reach_idx2", budget > 0, 1);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_valid", pix_valid, 0);
        check("midrst_idx", led_index, 0);
        check("midrst_busy", frame_busy, 0);
        check("midrst_data", pix_data, 0);
        frames_done = 0;
        posv = '{3, 3, 0, 1};
        do_frames(1, 1'b1, 1'b0, 1'b0);

        ready_mode = 2;
        repeat (20) begin
            for (int k = 0; k < 4; k++)
                posv[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(LC, 63))
                                                      : int'($urandom_range(0, LC - 1));
            do_frames(1, 1'b0, 1'b0, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
